i2c_master_arbiter: RTL and testbench
=====================================

// Module: i2c_master_arbiter
// PURPOSE
//  Shares one i2c repeater (master-side SCL/SDA, SDA direction tap) between two upstream I2C masters.
//  Grants the bus to the first master issuing START and forwards only that master's SCL/SDA downstream.
//  Holds the non-owner's SCL low (clock stretch) so it cannot start; releases the bus on STOP or on timeout.
//  Sits between the board-level master pins and the repeater's master_scl/master_sda port.
// PARAMETERS
//  DEBOUNCE     5       consecutive equal samples needed to accept a new SCL/SDA level
//  TIMEOUT_CYC  500000  system_clk cycles without an owner SCL edge before forced release
//  BUF_CYC      250     bus-free hold-off cycles after release before a new grant (tBUF)
// PORTS
//  system_clk    in   1  system clock, all state on posedge
//  reset         in   1  asynchronous, active-high
//  m_scl_in      in   2  raw SCL level seen at master k's pins, k = 0,1
//  m_sda_in      in   2  raw SDA level seen at master k's pins
//  m_scl_oe      out  2  1 = pull master k's SCL low (stretch)
//  m_sda_oe      out  2  1 = pull master k's SDA low (slave read data / ACK toward owner)
//  rep_scl       out  1  SCL to the repeater master side
//  rep_sda_oe    out  1  1 = pull the repeater master-side SDA low
//  rep_sda_in    in   1  level of the repeater master-side SDA
//  rep_dir_miso  in   1  repeater direction tap; 1 = slave currently drives SDA
//  grant         out  2  one-hot owner; 00 = none
//  busy          out  1  state != IDLE
//  timeout_err   out  1  1-cycle pulse on forced release
//  collision     out  1  1-cycle pulse when both masters START in the same cycle
// BEHAVIOUR
//  Reset:
//   - state = IDLE, grant = 00, last_owner = 1.
//   - All oe outputs = 0, rep_scl = 1.
//   - timeout_err = 0, collision = 0, all counters = 0.
//  Line monitors:
//   - Each master's SCL/SDA passes through a 2-FF sync and a DEBOUNCE filter.
//   - START = filtered SCL high on 2 consecutive cycles while filtered SDA falls.
//   - STOP = same SCL condition while filtered SDA rises.
//   - START/STOP are 1-cycle pulses.
//  Forwarding (combinational, raw inputs; o = owner):
//   - rep_scl = m_scl_in[o], or 1 when there is no owner.
//   - rep_sda_oe = owner_valid & !rep_dir_miso & !m_sda_in[o].
//   - m_sda_oe[o] = owner_valid & rep_dir_miso & !rep_sda_in.
//   - Using the direction tap prevents an open-drain lock-up loop. m_sda_oe of the non-owner = 0.
//  Stretch:
//   - m_scl_oe[k] = 1 in GRANT(!k) and in HOLDOFF for both k; 0 otherwise.
//  FSM (registered, next state takes effect on the following posedge):
//   - IDLE -> GRANT0/GRANT1 on a START from that master. The grant is registered 1 cycle after the START pulse.
//   - Both STARTs in the same cycle: grant !last_owner, pulse collision.
//   - Entering GRANTk: last_owner <= k. Downstream START appears when rep_sda_oe asserts while rep_scl is still high.
//   - Total latency DEBOUNCE+4 cycles, which must be < tHD;STA.
//   - GRANTk -> HOLDOFF on a STOP from master k. Repeated START keeps the grant.
//   - GRANTk -> HOLDOFF when idle_cnt reaches TIMEOUT_CYC-1; pulse timeout_err, rep_sda_oe forced 0.
//   - idle_cnt clears on every filtered owner SCL edge and saturates.
//   - HOLDOFF -> IDLE after BUF_CYC cycles. STARTs seen during HOLDOFF are ignored.
//  Boundaries:
//   - STOP and timeout in the same cycle: STOP wins, no timeout_err.
//   - START from the non-owner while granted (protocol violation): ignored.
//   - Reset mid-transfer: all outputs return to reset values immediately (async).
//   - Counters use $clog2(TIMEOUT_CYC) and $clog2(BUF_CYC) widths and never wrap.
// STRUCTURE
//  - i2c_pkg: arb_state_t {IDLE, GRANT0, GRANT1, HOLDOFF}, owner index type, default DEBOUNCE constant.
//  - Sub-module i2c_line_monitor: sync, debounce, start/stop detect. Instantiated once per master.
//  - Top level: FSM, counters, forwarding muxes.
// TESTING
//  1. M0 START, write 0x50 W + 1 byte, STOP -> grant=01 within DEBOUNCE+4 clk; byte seen on rep side;
//     m_scl_oe[1]=1 throughout; HOLDOFF BUF_CYC clk; then grant=00.
//  2. M1 read from 0x50 with rep_dir_miso=1 and rep_sda_in driving 0xA5 -> M1 sees 0xA5 on m_sda_oe;
//     rep_sda_oe=0 during data bits.
//  3. M0 and M1 START in the same cycle after reset -> grant=01 (last_owner=1), collision pulses once;
//     M1 stretched until HOLDOFF ends.
//  4. M0 START, then SCL frozen high -> timeout_err pulse at TIMEOUT_CYC; grant=00 after BUF_CYC;
//     a later M1 START is granted.
//  5. M0 repeated START mid-transaction, then M1 START during HOLDOFF -> grant stays 01 through the
//     repeated START; M1 START is ignored.
//  6. Assert reset during GRANT1 data phase -> all oe outputs = 0, rep_scl=1, grant=00 the same cycle.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared types and constants for the two-master I2C arbiter.
//   arb_state_t      : arbiter FSM states
//   owner_idx_t      : index of the upstream master that owns the bus
//   DEFAULT_DEBOUNCE : default number of equal samples needed to accept a line level
package i2c_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT0  = 2'd1,
    GRANT1  = 2'd2,
    HOLDOFF = 2'd3
  } arb_state_t;

  typedef logic owner_idx_t;

  localparam int unsigned DEFAULT_DEBOUNCE = 5;

endpackage

// File: rtl/i2c_line_monitor.sv
// Per-master line monitor: 2-FF synchroniser, debounce filter and START/STOP detection.
// Ports:
//   system_clk : clock, all state on posedge
//   reset      : asynchronous, active-high
//   scl_raw    : raw SCL level at the master's pins
//   sda_raw    : raw SDA level at the master's pins
//   scl_edge   : 1-cycle pulse on any filtered SCL transition
//   start      : 1-cycle pulse, filtered SDA fell while filtered SCL high for 2 cycles
//   stop       : 1-cycle pulse, filtered SDA rose while filtered SCL high for 2 cycles
module i2c_line_monitor import i2c_pkg::*; #(
  parameter int unsigned DEBOUNCE = DEFAULT_DEBOUNCE
) (
  input  logic system_clk,
  input  logic reset,
  input  logic scl_raw,
  input  logic sda_raw,
  output logic scl_edge,
  output logic start,
  output logic stop
);

  localparam int unsigned CntW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE - 1);

  // Bit 0 = SCL, bit 1 = SDA. Everything resets to the idle-high bus level.
  logic [1:0]      sync1_q, sync2_q, filt_q, prev_q;
  logic [CntW-1:0] cnt_q [2];

  always_ff @(posedge system_clk or posedge reset) begin
    if (reset) begin
      sync1_q  <= 2'b11;
      sync2_q  <= 2'b11;
      filt_q   <= 2'b11;
      prev_q   <= 2'b11;
      cnt_q[0] <= '0;
      cnt_q[1] <= '0;
    end else begin
      sync1_q <= {sda_raw, scl_raw};
      sync2_q <= sync1_q;
      prev_q  <= filt_q;
      for (int i = 0; i < 2; i++) begin
        // Count consecutive samples that disagree with the accepted level; any
        // agreeing sample restarts the count.
        if (sync2_q[i] == filt_q[i]) begin
          cnt_q[i] <= '0;
        end else if (cnt_q[i] == CntMax) begin
          filt_q[i] <= sync2_q[i];
          cnt_q[i]  <= '0;
        end else begin
          cnt_q[i] <= cnt_q[i] + CntW'(1);
        end
      end
    end
  end

  always_comb begin
    scl_edge = filt_q[0] ^ prev_q[0];
    start    = filt_q[0] & prev_q[0] & prev_q[1] & ~filt_q[1];
    stop     = filt_q[0] & prev_q[0] & ~prev_q[1] & filt_q[1];
  end

endmodule

// File: rtl/i2c_master_arbiter.sv
// Shares one I2C repeater master-side port between two upstream masters. The first master
// to issue START owns the bus; the other is clock-stretched until the bus is released by
// the owner's STOP or by an SCL inactivity timeout, followed by a bus-free hold-off.
// Ports:
//   system_clk   : clock, all state on posedge
//   reset        : asynchronous, active-high
//   m_scl_in     : raw SCL level at master k's pins (k = 0,1)
//   m_sda_in     : raw SDA level at master k's pins
//   m_scl_oe     : 1 = pull master k's SCL low (stretch)
//   m_sda_oe     : 1 = pull master k's SDA low (slave data / ACK towards owner)
//   rep_scl      : SCL to the repeater master side
//   rep_sda_oe   : 1 = pull repeater master-side SDA low
//   rep_sda_in   : level of repeater master-side SDA
//   rep_dir_miso : repeater direction tap, 1 = slave drives SDA
//   grant        : one-hot owner, 00 = none
//   busy         : arbiter not idle
//   timeout_err  : 1-cycle pulse on forced release
//   collision    : 1-cycle pulse when both masters START in the same cycle
module i2c_master_arbiter import i2c_pkg::*; #(
  parameter int unsigned DEBOUNCE    = DEFAULT_DEBOUNCE,
  parameter int unsigned TIMEOUT_CYC = 500000,
  parameter int unsigned BUF_CYC     = 250
) (
  input  logic       system_clk,
  input  logic       reset,
  input  logic [1:0] m_scl_in,
  input  logic [1:0] m_sda_in,
  output logic [1:0] m_scl_oe,
  output logic [1:0] m_sda_oe,
  output logic       rep_scl,
  output logic       rep_sda_oe,
  input  logic       rep_sda_in,
  input  logic       rep_dir_miso,
  output logic [1:0] grant,
  output logic       busy,
  output logic       timeout_err,
  output logic       collision
);

  localparam int unsigned IdleW = $clog2(TIMEOUT_CYC);
  localparam int unsigned BufW  = $clog2(BUF_CYC);
  localparam logic [IdleW-1:0] IdleMax = IdleW'(TIMEOUT_CYC - 1);
  localparam logic [BufW-1:0]  BufMax  = BufW'(BUF_CYC - 1);

  logic [1:0] scl_edge, start, stop;

  for (genvar k = 0; k < 2; k++) begin : g_mon
    i2c_line_monitor #(
      .DEBOUNCE (DEBOUNCE)
    ) u_mon (
      .system_clk (system_clk),
      .reset      (reset),
      .scl_raw    (m_scl_in[k]),
      .sda_raw    (m_sda_in[k]),
      .scl_edge   (scl_edge[k]),
      .start      (start[k]),
      .stop       (stop[k])
    );
  end

  arb_state_t       state_q, state_d;
  owner_idx_t       last_owner_q, last_owner_d;
  logic [IdleW-1:0] idle_cnt_q, idle_cnt_d;
  logic [BufW-1:0]  buf_cnt_q, buf_cnt_d;
  logic             timeout_q, timeout_d;
  logic             collision_q, collision_d;

  logic       owner_valid;
  owner_idx_t owner;

  assign owner_valid = (state_q == GRANT0) || (state_q == GRANT1);
  assign owner       = (state_q == GRANT1);

  always_ff @(posedge system_clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      last_owner_q <= 1'b1;
      idle_cnt_q   <= '0;
      buf_cnt_q    <= '0;
      timeout_q    <= 1'b0;
      collision_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
      idle_cnt_q   <= idle_cnt_d;
      buf_cnt_q    <= buf_cnt_d;
      timeout_q    <= timeout_d;
      collision_q  <= collision_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_owner_d = last_owner_q;
    idle_cnt_d   = idle_cnt_q;
    buf_cnt_d    = buf_cnt_q;
    timeout_d    = 1'b0;
    collision_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        idle_cnt_d = '0;
        buf_cnt_d  = '0;
        if (start[0] && start[1]) begin
          // Simultaneous START: alternate away from the previous owner.
          collision_d = 1'b1;
          if (last_owner_q) begin
            state_d      = GRANT0;
            last_owner_d = 1'b0;
          end else begin
            state_d      = GRANT1;
            last_owner_d = 1'b1;
          end
        end else if (start[0]) begin
          state_d      = GRANT0;
          last_owner_d = 1'b0;
        end else if (start[1]) begin
          state_d      = GRANT1;
          last_owner_d = 1'b1;
        end
      end
      GRANT0, GRANT1: begin
        // STOP is checked first so it beats a coincident timeout.
        if (stop[owner]) begin
          state_d    = HOLDOFF;
          idle_cnt_d = '0;
        end else if (idle_cnt_q == IdleMax) begin
          state_d    = HOLDOFF;
          timeout_d  = 1'b1;
          idle_cnt_d = '0;
        end else if (scl_edge[owner]) begin
          idle_cnt_d = '0;
        end else begin
          idle_cnt_d = idle_cnt_q + IdleW'(1);
        end
      end
      HOLDOFF: begin
        if (buf_cnt_q == BufMax) begin
          state_d   = IDLE;
          buf_cnt_d = '0;
        end else begin
          buf_cnt_d = buf_cnt_q + BufW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Forwarding uses the raw pins so downstream timing is not delayed by the filters.
  // The direction tap decides which side drives SDA, breaking the open-drain loop.
  always_comb begin
    grant       = {state_q == GRANT1, state_q == GRANT0};
    busy        = (state_q != IDLE);
    timeout_err = timeout_q;
    collision   = collision_q;
    rep_scl     = owner_valid ? m_scl_in[owner] : 1'b1;
    rep_sda_oe  = owner_valid & ~rep_dir_miso & ~m_sda_in[owner];
    m_sda_oe    = 2'b00;
    if (owner_valid) begin
      m_sda_oe[owner] = rep_dir_miso & ~rep_sda_in;
    end
    unique case (state_q)
      GRANT0:  m_scl_oe = 2'b10;
      GRANT1:  m_scl_oe = 2'b01;
      HOLDOFF: m_scl_oe = 2'b11;
      default: m_scl_oe = 2'b00;
    endcase
  end

endmodule

// File: tb/tb_i2c_master_arbiter.sv
// Directed bench for i2c_master_arbiter: two bit-banged masters, hand-computed expectations.
module tb_i2c_master_arbiter;

  localparam int unsigned DEB = 5;
  localparam int unsigned TO  = 200;
  localparam int unsigned BUF = 20;
  localparam int unsigned H   = 10;  // quarter SCL period in system_clk cycles

  logic       system_clk = 1'b0;
  logic       reset      = 1'b1;
  logic [1:0] m_scl_in   = 2'b11;
  logic [1:0] m_sda_in   = 2'b11;
  logic [1:0] m_scl_oe, m_sda_oe, grant;
  logic       rep_scl, rep_sda_oe, busy, timeout_err, collision;
  logic       rep_sda_in   = 1'b1;
  logic       rep_dir_miso = 1'b0;

  int checks = 0;
  int errors = 0;

  logic [7:0] seen;
  logic       ack, held, quiet;

  always #5 system_clk = ~system_clk;

  i2c_master_arbiter #(
    .DEBOUNCE    (DEB),
    .TIMEOUT_CYC (TO),
    .BUF_CYC     (BUF)
  ) dut (
    .system_clk   (system_clk),
    .reset        (reset),
    .m_scl_in     (m_scl_in),
    .m_sda_in     (m_sda_in),
    .m_scl_oe     (m_scl_oe),
    .m_sda_oe     (m_sda_oe),
    .rep_scl      (rep_scl),
    .rep_sda_oe   (rep_sda_oe),
    .rep_sda_in   (rep_sda_in),
    .rep_dir_miso (rep_dir_miso),
    .grant        (grant),
    .busy         (busy),
    .timeout_err  (timeout_err),
    .collision    (collision)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge system_clk);
  endtask

  // Writes one byte plus a slave ACK; returns the bits seen downstream, the ACK seen by
  // the master and whether the other master stayed stretched at every sample.
  task automatic write_byte(input int k, input logic [7:0] b, output logic [7:0] s,
                            output logic a, output logic h);
    h = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      m_scl_in[k] = 1'b0; tick(H);
      m_sda_in[k] = b[i]; tick(H);
      m_scl_in[k] = 1'b1; tick(H);
      s[i] = ~rep_sda_oe;
      h    = h & m_scl_oe[1-k];
      tick(H);
    end
    m_scl_in[k] = 1'b0; tick(H);
    m_sda_in[k] = 1'b1; rep_dir_miso = 1'b1; rep_sda_in = 1'b0; tick(H);
    m_scl_in[k] = 1'b1; tick(H);
    a = m_sda_oe[k];
    tick(H);
    m_scl_in[k] = 1'b0; tick(1);
    rep_dir_miso = 1'b0; rep_sda_in = 1'b1;
  endtask

  task automatic read_byte(input int k, input logic [7:0] d, output logic [7:0] g,
                           output logic q);
    q = 1'b1;
    rep_dir_miso = 1'b1;
    m_sda_in[k]  = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      m_scl_in[k] = 1'b0; tick(H);
      rep_sda_in = d[i]; tick(H);
      m_scl_in[k] = 1'b1; tick(H);
      g[i] = ~m_sda_oe[k];
      q    = q & ~rep_sda_oe;
      tick(H);
    end
    m_scl_in[k] = 1'b0; tick(H);
    rep_dir_miso = 1'b0; rep_sda_in = 1'b1;
  endtask

  // Ends with the SDA rising edge just driven; the caller times the grant release.
  task automatic stop_cond(input int k);
    m_scl_in[k] = 1'b0; tick(H);
    m_sda_in[k] = 1'b0; tick(H);
    m_scl_in[k] = 1'b1; tick(H);
    m_sda_in[k] = 1'b1;
  endtask

  task automatic rstart(input int k);
    m_scl_in[k] = 1'b0; tick(H);
    m_sda_in[k] = 1'b1; tick(H);
    m_scl_in[k] = 1'b1; tick(H);
    m_sda_in[k] = 1'b0; tick(H);
  endtask

  initial begin
    // Reset state
    tick(3);
    chk("rst_grant", grant, 2'b00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_scl_oe", m_scl_oe, 2'b00);
    chk("rst_sda_oe", m_sda_oe, 2'b00);
    chk("rst_rep_scl", rep_scl, 1'b1);
    chk("rst_rep_sda_oe", rep_sda_oe, 1'b0);
    chk("rst_flags", {timeout_err, collision}, 2'b00);
    reset = 1'b0;
    tick(5);

    // 1: M0 writes 0xA0, 0x3C
    m_sda_in[0] = 1'b0;
    tick(DEB + 2);
    chk("t1_grant_early", grant, 2'b00);
    tick(1);
    chk("t1_grant", grant, 2'b01);
    chk("t1_stretch", m_scl_oe, 2'b10);
    chk("t1_rep_start", {rep_scl, rep_sda_oe}, 2'b11);
    tick(H);
    write_byte(0, 8'hA0, seen, ack, held);
    chk("t1_addr", seen, 8'hA0);
    chk("t1_addr_ack", ack, 1'b1);
    chk("t1_addr_held", held, 1'b1);
    write_byte(0, 8'h3C, seen, ack, held);
    chk("t1_data", seen, 8'h3C);
    chk("t1_data_held", held, 1'b1);
    stop_cond(0);
    tick(DEB + 2);
    chk("t1_before_stop", grant, 2'b01);
    tick(1);
    chk("t1_holdoff", {grant, busy, m_scl_oe}, 5'b00111);
    tick(BUF - 1);
    chk("t1_holdoff_end", busy, 1'b1);
    tick(1);
    chk("t1_idle", {busy, m_scl_oe}, 3'b000);

    // 2: M1 reads 0xA5
    m_sda_in[1] = 1'b0;
    tick(DEB + 3);
    chk("t2_grant", grant, 2'b10);
    chk("t2_stretch", m_scl_oe, 2'b01);
    tick(H);
    write_byte(1, 8'hA1, seen, ack, held);
    chk("t2_addr", seen, 8'hA1);
    read_byte(1, 8'hA5, seen, quiet);
    chk("t2_rdata", seen, 8'hA5);
    chk("t2_rep_quiet", quiet, 1'b1);
    chk("t2_sda_oe_off", m_sda_oe, 2'b00);
    stop_cond(1);
    tick(DEB + 3 + BUF + 2);
    chk("t2_idle", busy, 1'b0);

    // 3: simultaneous START after reset
    reset = 1'b1; tick(2);
    reset = 1'b0; tick(2);
    m_sda_in = 2'b00;
    tick(DEB + 3);
    chk("t3_grant", grant, 2'b01);
    chk("t3_collision", collision, 1'b1);
    chk("t3_stretch", m_scl_oe, 2'b10);
    tick(1);
    chk("t3_collision_pulse", collision, 1'b0);
    stop_cond(0);
    tick(DEB + 3);
    chk("t3_holdoff", {grant, m_scl_oe}, 4'b0011);
    tick(BUF);
    chk("t3_released", {busy, grant, m_scl_oe}, 5'b00000);
    m_sda_in[1] = 1'b1;
    tick(20);

    // 4: SCL frozen high -> timeout, then M1 granted
    m_sda_in[0] = 1'b0;
    tick(DEB + 3);
    chk("t4_grant", grant, 2'b01);
    tick(TO - 1);
    chk("t4_pre_timeout", {grant, timeout_err}, 3'b010);
    tick(1);
    chk("t4_timeout", {grant, timeout_err, busy}, 4'b0011);
    chk("t4_forced_sda", rep_sda_oe, 1'b0);
    tick(1);
    chk("t4_timeout_pulse", timeout_err, 1'b0);
    m_sda_in[0] = 1'b1;
    tick(BUF - 2);
    chk("t4_holdoff", busy, 1'b1);
    tick(1);
    chk("t4_idle", busy, 1'b0);
    m_sda_in[1] = 1'b0;
    tick(DEB + 3);
    chk("t4_m1_grant", grant, 2'b10);
    stop_cond(1);
    tick(DEB + 3 + BUF + 2);

    // 5: non-owner START, repeated START, START during HOLDOFF
    m_sda_in[0] = 1'b0;
    tick(DEB + 3);
    chk("t5_grant", grant, 2'b01);
    tick(H);
    write_byte(0, 8'hA0, seen, ack, held);
    m_sda_in[1] = 1'b0; tick(H);
    chk("t5_nonowner_start", grant, 2'b01);
    m_sda_in[1] = 1'b1; tick(H);
    chk("t5_nonowner_stop", grant, 2'b01);
    rstart(0);
    chk("t5_rstart", grant, 2'b01);
    write_byte(0, 8'hA1, seen, ack, held);
    chk("t5_after_rstart", {seen, grant}, {8'hA1, 2'b01});
    stop_cond(0);
    tick(DEB + 3);
    chk("t5_holdoff", {grant, busy}, 3'b001);
    tick(2);
    m_sda_in[1] = 1'b0;
    tick(BUF);
    chk("t5_ignored", {grant, busy}, 3'b000);
    tick(20);
    chk("t5_still_idle", grant, 2'b00);
    m_sda_in[1] = 1'b1;
    tick(20);

    // 6: async reset in GRANT1 data phase
    m_sda_in[1] = 1'b0;
    tick(DEB + 3);
    chk("t6_grant", grant, 2'b10);
    tick(H);
    write_byte(1, 8'hA1, seen, ack, held);
    rep_dir_miso = 1'b1; m_sda_in[1] = 1'b1; m_scl_in[1] = 1'b0; tick(H);
    rep_sda_in = 1'b0; tick(H);
    chk("t6_active", {m_sda_oe, m_scl_oe}, 4'b1001);
    reset = 1'b1;
    #1;
    chk("t6_oe", {m_scl_oe, m_sda_oe, rep_sda_oe}, 5'b00000);
    chk("t6_rep_scl", rep_scl, 1'b1);
    chk("t6_grant_busy", {grant, busy}, 3'b000);
    m_scl_in = 2'b11; m_sda_in = 2'b11; rep_dir_miso = 1'b0; rep_sda_in = 1'b1;
    tick(3);
    reset = 1'b0;
    tick(5);
    chk("t6_after_reset", {grant, busy}, 3'b000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
